// File: rtl/cvxif_pkg.sv
// CV-X-IF type definitions shared by the coprocessor-facing blocks.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH   = 3;
  localparam int unsigned X_DATA_WIDTH = 32;
  localparam int unsigned X_RD_WIDTH   = 5;
  localparam int unsigned X_EXC_WIDTH  = 6;

  // Result returned by the coprocessor for one offloaded instruction.
  typedef struct packed {
    logic [X_ID_WIDTH-1:0]   id;
    logic [X_DATA_WIDTH-1:0] data;
    logic [X_RD_WIDTH-1:0]   rd;
    logic                    we;
    logic                    exc;
    logic [X_EXC_WIDTH-1:0]  exccode;
  } x_result_t;

  // Commit decision from the core for one offloaded instruction.
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;

endpackage

// File: rtl/cvxif_result_queue.sv
// cvxif_result_queue
// In-order buffer between the CV-X-IF coprocessor result port and the core
// writeback stage. Results whose instruction was killed on the commit
// interface are dropped at acceptance instead of being queued.
//
// Optional feature macro: CVXIF_RESULT_QUEUE_BYPASS_EN
//   defined   - an accepted, non-dropped result arriving at an empty queue
//               falls through combinationally to wb_*; if the core takes it
//               in that cycle it is never stored.
//   undefined - wb_* are driven only from storage (one cycle minimum latency).
module cvxif_result_queue
  import cvxif_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned NbIds = 2**X_ID_WIDTH
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      clr_i,
  input  logic      x_result_valid_i,
  output logic      x_result_ready_o,
  input  x_result_t x_result_i,
  input  logic      x_commit_valid_i,
  input  x_commit_t x_commit_i,
  output logic      wb_valid_o,
  input  logic      wb_ready_i,
  output x_result_t wb_result_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] CountFull = CntW'(Depth);

  x_result_t        mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic [NbIds-1:0] killed_q, killed_d;

  logic empty;
  logic accept;
  logic kill_same_cycle;
  logic drop;
  logic push;
  logic pop;

  // Full is judged on the registered count only, so a pop in the same cycle
  // never opens a slot for a push.
  assign x_result_ready_o = (count_q != CountFull);
  assign empty            = (count_q == '0);
  assign accept           = x_result_valid_i & x_result_ready_o;

  // A result is dropped if its id was killed earlier or is being killed now.
  assign kill_same_cycle = x_commit_valid_i & x_commit_i.x_commit_kill
                         & (x_commit_i.id == x_result_i.id);
  assign drop            = killed_q[x_result_i.id] | kill_same_cycle;

`ifdef CVXIF_RESULT_QUEUE_BYPASS_EN
  logic bypass;

  assign bypass      = empty & accept & ~drop;
  assign wb_valid_o  = ~empty | bypass;
  assign wb_result_o = bypass ? x_result_i : mem_q[rptr_q];
  // Only stored entries advance the read side; a consumed bypass is never
  // written, so neither pointer moves for it.
  assign pop         = ~empty & wb_ready_i;
  assign push        = accept & ~drop & ~(bypass & wb_ready_i);
`else
  assign wb_valid_o  = ~empty;
  assign wb_result_o = mem_q[rptr_q];
  assign pop         = wb_valid_o & wb_ready_i;
  assign push        = accept & ~drop;
`endif

  // Kill table next state: commit sets/clears, then a dropped result clears
  // its own bit last so a same-cycle kill and drop ends with the bit clear.
  always_comb begin
    // NOTE: every variable assigned here gets a full default first, so no
    // path leaves it unassigned and no latch is inferred.
    killed_d = killed_q;
    if (x_commit_valid_i) begin
      killed_d[x_commit_i.id] = x_commit_i.x_commit_kill;
    end
    if (accept && drop) begin
      killed_d[x_result_i.id] = 1'b0;
    end
  end

  // Pointers, occupancy and kill table; clr_i overrides any push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      killed_q <= '0;
    end else if (clr_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      killed_q <= '0;
    end else begin
      killed_q <= killed_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Result storage; written at the write pointer on every stored accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the storage array is reset on purpose: wb_result_o reads it
    // directly and must come out of reset as all zeros.
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (push && !clr_i) begin
      mem_q[wptr_q] <= x_result_i;
    end
  end

endmodule

// File: tb/tb_cvxif_result_queue.sv
// Self-checking bench for cvxif_result_queue: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_cvxif_result_queue;
  import cvxif_pkg::*;

  localparam int DEPTH  = 4;
  localparam int NB_IDS = 2**X_ID_WIDTH;

  logic      clk_i = 1'b0;
  logic      rst_ni;
  logic      clr;
  logic      r_valid;
  logic      r_ready;
  x_result_t r_pay;
  logic      c_valid;
  x_commit_t c_pay;
  logic      wb_valid;
  logic      wb_ready;
  x_result_t wb_result;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of stored results and a kill flag per id.
  x_result_t mq[$];
  bit        killed_m[NB_IDS];
  x_result_t dut_out[$];

  logic      exp_ready, exp_valid;
  x_result_t exp_result;
  logic      obs_ready, obs_valid;
  x_result_t obs_result;

  cvxif_result_queue #(.Depth(DEPTH), .NbIds(NB_IDS)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clr_i            (clr),
    .x_result_valid_i (r_valid),
    .x_result_ready_o (r_ready),
    .x_result_i       (r_pay),
    .x_commit_valid_i (c_valid),
    .x_commit_i       (c_pay),
    .wb_valid_o       (wb_valid),
    .wb_ready_i       (wb_ready),
    .wb_result_o      (wb_result)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic x_result_t mk(input int id, input logic [31:0] data,
                                   input int rd, input logic we,
                                   input logic exc, input int code);
    x_result_t r;
    r.id      = id[X_ID_WIDTH-1:0];
    r.data    = data;
    r.rd      = rd[4:0];
    r.we      = we;
    r.exc     = exc;
    r.exccode = code[5:0];
    return r;
  endfunction

  task automatic idle();
    r_valid = 1'b0;
    c_valid = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic model_clear();
    mq.delete();
    foreach (killed_m[i]) killed_m[i] = 1'b0;
  endtask

  // One clock: predict outputs from the model, sample the DUT, then advance
  // the model by the rules of acceptance, kill, pop and clear.
  task automatic cycle();
    bit acc, drp, byp;
    #1;
    exp_ready = (mq.size() < DEPTH);
    acc = r_valid && exp_ready;
    drp = acc && (killed_m[r_pay.id] ||
                  (c_valid && c_pay.x_commit_kill && c_pay.id == r_pay.id));
`ifdef CVXIF_RESULT_QUEUE_BYPASS_EN
    byp = acc && !drp && (mq.size() == 0);
`else
    byp = 1'b0;
`endif
    exp_valid  = (mq.size() > 0) || byp;
    exp_result = (mq.size() > 0) ? mq[0] : r_pay;
    obs_ready  = r_ready;
    obs_valid  = wb_valid;
    obs_result = wb_result;
    if (obs_valid && wb_ready) dut_out.push_back(obs_result);
    @(posedge clk_i);
    if (clr) begin
      model_clear();
    end else begin
      if (c_valid) killed_m[c_pay.id] = c_pay.x_commit_kill;
      if (drp) killed_m[r_pay.id] = 1'b0;
      if (exp_valid && wb_ready && mq.size() > 0) void'(mq.pop_front());
      if (acc && !drp && !(byp && wb_ready)) mq.push_back(r_pay);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni   = 1'b0;
    wb_ready = 1'b0;
    r_pay    = '0;
    c_pay    = '0;
    idle();
    model_clear();
    repeat (2) @(negedge clk_i);
    #1;
    total++;
    if (r_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", r_ready);
    end
    total++;
    if (wb_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", wb_valid);
    end
    total++;
    if (wb_result !== '0) begin
      bad++; $display("FAIL reset_result: got %h want 0", wb_result);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    x_result_t p;
    p = mk(3, 32'h1234, 5, 1'b1, 1'b0, 0);
    idle();
    dut_out.delete();
    wb_ready = 1'b1;
    r_valid  = 1'b1;
    r_pay    = p;
    for (int c = 0; c < 3; c++) begin
      cycle();
      r_valid = 1'b0;
      total++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready ||
          (exp_valid && obs_result !== exp_result)) begin
        bad++;
        $display("FAIL single_model c%0d: got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 c, obs_valid, obs_ready, obs_result, exp_valid, exp_ready, exp_result);
      end
`ifndef CVXIF_RESULT_QUEUE_BYPASS_EN
      if (c < 2) begin
        total++;
        if (obs_valid !== (c == 1)) begin
          bad++; $display("FAIL single_latency c%0d: got valid=%b want %b", c, obs_valid, c == 1);
        end
      end
`endif
    end
    total++;
    if (obs_valid !== 1'b0) begin
      bad++; $display("FAIL single_empty_after: got valid=%b want 0", obs_valid);
    end
    total++;
    if (dut_out.size() != 1 || dut_out[0] !== p) begin
      bad++;
      $display("FAIL single_payload: got %0d results first=%h want 1 result %h",
               dut_out.size(), (dut_out.size() > 0) ? dut_out[0] : '0, p);
    end
  endtask

  task automatic test_fill();
    int nxt = 0;
    idle();
    dut_out.delete();
    wb_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      r_valid = 1'b1;
      r_pay   = mk(nxt, 32'hA000 + nxt, nxt + 1, 1'b1, nxt[0], nxt);
      cycle();
      if (obs_ready) nxt++;
      total++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready ||
          (exp_valid && obs_result !== exp_result)) begin
        bad++;
        $display("FAIL fill_model c%0d: got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 c, obs_valid, obs_ready, obs_result, exp_valid, exp_ready, exp_result);
      end
    end
    total++;
    if (nxt != 4) begin
      bad++; $display("FAIL fill_accepted: got %0d want 4", nxt);
    end
    total++;
    if (obs_ready !== 1'b0) begin
      bad++; $display("FAIL fill_ready_low: got %b want 0", obs_ready);
    end
    // Release backpressure with id 4 still held at the source.
    wb_ready = 1'b1;
    cycle();
    total++;
    if (obs_ready !== 1'b0) begin
      bad++; $display("FAIL fill_no_push_on_pop: got ready=%b want 0", obs_ready);
    end
    cycle();
    total++;
    if (obs_ready !== 1'b1) begin
      bad++; $display("FAIL fill_ready_return: got ready=%b want 1", obs_ready);
    end
    r_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      total++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready ||
          (exp_valid && obs_result !== exp_result)) begin
        bad++;
        $display("FAIL fill_drain c%0d: got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 c, obs_valid, obs_ready, obs_result, exp_valid, exp_ready, exp_result);
      end
    end
    total++;
    if (dut_out.size() != 5) begin
      bad++; $display("FAIL fill_count: got %0d results want 5", dut_out.size());
    end
    for (int i = 0; i < dut_out.size() && i < 5; i++) begin
      total++;
      if (dut_out[i].id !== X_ID_WIDTH'(i) || dut_out[i].data !== 32'hA000 + i) begin
        bad++;
        $display("FAIL fill_order[%0d]: got id=%0d data=%h want id=%0d data=%h",
                 i, dut_out[i].id, dut_out[i].data, i, 32'hA000 + i);
      end
    end
  endtask

  task automatic test_kill_before();
    idle();
    dut_out.delete();
    wb_ready = 1'b1;
    c_valid = 1'b1;
    c_pay.id = X_ID_WIDTH'(2);
    c_pay.x_commit_kill = 1'b1;
    cycle();
    c_valid = 1'b0;
    cycle();
    cycle();
    r_valid = 1'b1;
    r_pay   = mk(2, 32'hDEAD0002, 7, 1'b1, 1'b0, 0);
    cycle();
    total++;
    if (obs_ready !== 1'b1) begin
      bad++; $display("FAIL kill_accept_ready: got %b want 1", obs_ready);
    end
    r_pay = mk(3, 32'h0000BEE3, 8, 1'b1, 1'b1, 13);
    cycle();
    r_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready ||
          (exp_valid && obs_result !== exp_result)) begin
        bad++;
        $display("FAIL kill_model c%0d: got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 c, obs_valid, obs_ready, obs_result, exp_valid, exp_ready, exp_result);
      end
    end
    total++;
    if (dut_out.size() != 1 || dut_out[0].id !== X_ID_WIDTH'(3)) begin
      bad++;
      $display("FAIL kill_dropped: got %0d results first id=%0d want 1 result id=3",
               dut_out.size(), (dut_out.size() > 0) ? dut_out[0].id : '0);
    end
    // The kill bit must have been consumed by the dropped result.
    r_valid = 1'b1;
    r_pay   = mk(2, 32'h00002222, 9, 1'b0, 1'b0, 0);
    cycle();
    r_valid = 1'b0;
    cycle();
    cycle();
    total++;
    if (dut_out.size() != 2 || dut_out[dut_out.size()-1].data !== 32'h00002222) begin
      bad++;
      $display("FAIL kill_bit_cleared: got %0d results want 2 ending data=00002222",
               dut_out.size());
    end
  endtask

  task automatic test_simul_kill();
    idle();
    dut_out.delete();
    wb_ready = 1'b1;
    c_valid = 1'b1;
    c_pay.id = X_ID_WIDTH'(1);
    c_pay.x_commit_kill = 1'b1;
    r_valid = 1'b1;
    r_pay   = mk(1, 32'h11111111, 1, 1'b1, 1'b0, 0);
    cycle();
    total++;
    if (obs_valid !== 1'b0) begin
      bad++; $display("FAIL simkill_same_cycle: got valid=%b want 0", obs_valid);
    end
    idle();
    cycle();
    total++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      bad++; $display("FAIL simkill_after: got valid=%b ready=%b want 0 1", obs_valid, obs_ready);
    end
    r_valid = 1'b1;
    r_pay   = mk(1, 32'h1111AAAA, 1, 1'b1, 1'b0, 0);
    cycle();
    r_valid = 1'b0;
    cycle();
    cycle();
    total++;
    if (dut_out.size() != 1 || dut_out[0].data !== 32'h1111AAAA) begin
      bad++; $display("FAIL simkill_bit_cleared: got %0d results want 1 data=1111aaaa",
                      dut_out.size());
    end
  endtask

  task automatic test_wrap();
    idle();
    dut_out.delete();
    wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r_valid = 1'b1;
      r_pay   = mk(i % NB_IDS, 32'h100 + i, i, i[0], i[1], i);
      cycle();
      total++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready ||
          (exp_valid && obs_result !== exp_result)) begin
        bad++;
        $display("FAIL wrap_model i%0d: got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 i, obs_valid, obs_ready, obs_result, exp_valid, exp_ready, exp_result);
      end
`ifdef CVXIF_RESULT_QUEUE_BYPASS_EN
      total++;
      if (obs_valid !== 1'b1) begin
        bad++; $display("FAIL wrap_bypass i%0d: got valid=%b want 1", i, obs_valid);
      end
`endif
    end
    r_valid = 1'b0;
    cycle();
    cycle();
    total++;
    if (dut_out.size() != 10) begin
      bad++; $display("FAIL wrap_count: got %0d results want 10", dut_out.size());
    end
    for (int i = 0; i < dut_out.size() && i < 10; i++) begin
      total++;
      if (dut_out[i].data !== 32'h100 + i) begin
        bad++; $display("FAIL wrap_order[%0d]: got data=%h want %h", i, dut_out[i].data, 32'h100 + i);
      end
    end
  endtask

  task automatic test_clear();
    idle();
    dut_out.delete();
    wb_ready = 1'b0;
    c_valid = 1'b1;
    c_pay.id = X_ID_WIDTH'(6);
    c_pay.x_commit_kill = 1'b1;
    cycle();
    c_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_valid = 1'b1;
      r_pay   = mk(i, 32'hC000 + i, i, 1'b1, 1'b0, 0);
      cycle();
    end
    clr   = 1'b1;
    r_pay = mk(4, 32'hC004, 4, 1'b1, 1'b0, 0);
    cycle();
    idle();
    cycle();
    total++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      bad++; $display("FAIL clear_state: got valid=%b ready=%b want 0 1", obs_valid, obs_ready);
    end
    wb_ready = 1'b1;
    cycle();
    cycle();
    total++;
    if (dut_out.size() != 0) begin
      bad++; $display("FAIL clear_leftover: got %0d results want 0", dut_out.size());
    end
    // Kill on id 6 must have been wiped by the clear.
    r_valid = 1'b1;
    r_pay   = mk(6, 32'hC006, 6, 1'b1, 1'b0, 0);
    cycle();
    r_valid = 1'b0;
    cycle();
    cycle();
    total++;
    if (dut_out.size() != 1 || dut_out[0].data !== 32'hC006) begin
      bad++; $display("FAIL clear_kill_table: got %0d results want 1 data=0000c006", dut_out.size());
    end
  endtask

  task automatic test_async_reset();
    idle();
    wb_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_valid = 1'b1;
      r_pay   = mk(i, 32'hF000 + i, i, 1'b1, 1'b0, 0);
      cycle();
    end
    idle();
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if (wb_valid !== 1'b0 || r_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset: got valid=%b ready=%b want 0 1", wb_valid, r_ready);
    end
    model_clear();
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle();
    total++;
    if (obs_valid !== exp_valid || obs_ready !== exp_ready) begin
      bad++; $display("FAIL async_reset_after: got v=%b r=%b want v=%b r=%b",
                      obs_valid, obs_ready, exp_valid, exp_ready);
    end
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 400; c++) begin
      r_valid  = $urandom_range(0, 1) == 1;
      r_pay    = mk($urandom_range(0, NB_IDS - 1), $urandom(), $urandom_range(0, 31),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 63));
      c_valid  = $urandom_range(0, 3) == 0;
      c_pay.id = X_ID_WIDTH'($urandom_range(0, NB_IDS - 1));
      c_pay.x_commit_kill = $urandom_range(0, 1) == 1;
      wb_ready = $urandom_range(0, 2) != 0;
      clr      = $urandom_range(0, 63) == 0;
      cycle();
      total++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready ||
          (exp_valid && obs_result !== exp_result)) begin
        bad++;
        $display("FAIL random_model c%0d: got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 c, obs_valid, obs_ready, obs_result, exp_valid, exp_ready, exp_result);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_kill_before();
    test_simul_kill();
    test_wrap();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
